// File: rtl/bp_common_pkg.sv
// Shared TLB types: tag/PTE struct macros and walk FSM states.
// Width-dependent structs are macros so each instance picks its own widths.
`ifndef BP_COMMON_PKG_MACROS
`define BP_COMMON_PKG_MACROS
`define BP_PTE_ENTRY_LEAF_S(ptag_w) \
  struct packed { \
    logic [ptag_w-1:0] ptag; \
    logic g; logic a; logic d; logic u; \
    logic x; logic w; logic r; logic v; \
  }
`define BP_TLB_TAG_S(asid_w, vtag_w) \
  struct packed { \
    logic [asid_w-1:0] asid; \
    logic [vtag_w-1:0] vtag; \
    logic g; \
  }
`endif

package bp_common_pkg;

  typedef enum logic [0:0] {
    e_tlb_idle = 1'b0,
    e_tlb_walk = 1'b1
  } bp_tlb_fsm_e;

  // position of the global bit in a flat leaf PTE
  localparam int bp_pte_g_bit_gp = 7;

endpackage

// File: rtl/bp_tlb_plru_tree.sv
// Tree pseudo-LRU; a node bit of 1 points the victim at its right subtree.
// Victim is combinational from the tree bits.
module bp_tlb_plru_tree
  import bp_common_pkg::*;
#(
  parameter int els_p = 8,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic                 touch_v_i,
  input  logic [lg_els_lp-1:0] touch_way_i,
  output logic [lg_els_lp-1:0] victim_o
);

  logic [els_p-1:1] bits_r, bits_n;
  logic [lg_els_lp-1:0] tnode, vnode;

  always_comb begin
    bits_n = bits_r;
    tnode = lg_els_lp'(1);
    for (int l = 0; l < lg_els_lp; l++) begin
      bits_n[tnode] = ~touch_way_i[lg_els_lp-1-l];
      tnode = lg_els_lp'({tnode, touch_way_i[lg_els_lp-1-l]});
    end
  end

  always_comb begin
    victim_o = '0;
    vnode = lg_els_lp'(1);
    for (int l = 0; l < lg_els_lp; l++) begin
      victim_o[lg_els_lp-1-l] = bits_r[vnode];
      vnode = lg_els_lp'({vnode, bits_r[vnode]});
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      bits_r <= '0;
    else if (clear_i)
      bits_r <= '0;
    else if (touch_v_i)
      bits_r <= bits_n;
  end

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or write per cycle.
// Read data holds until the next read.
module bsg_mem_1rw_sync #(
  parameter int width_p = 36,
  parameter int els_p = 8,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 v_i,
  input  logic                 w_i,
  input  logic [lg_els_lp-1:0] addr_i,
  input  logic [width_p-1:0]   data_i,
  output logic [width_p-1:0]   data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i)
      mem[addr_i] <= data_i;
    else if (v_i)
      data_o <= mem[addr_i];
  end

endmodule

// File: rtl/bp_tlb_asid.sv
// ASID-tagged fully-associative TLB with last-hit bypass and ASID flush walk.
// BP_TLB_PERF_CNT_EN enables saturating hit/miss/bypass counters.
module bp_tlb_asid
  import bp_common_pkg::*;
#(
  parameter int els_p = 8,
  parameter int vtag_width_p = 27,
  parameter int ptag_width_p = 28,
  parameter int asid_width_p = 10,
  parameter int entry_width_p = ptag_width_p + 8,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     translation_en_i,
  input  logic                     flush_v_i,
  input  logic                     flush_asid_v_i,
  input  logic [asid_width_p-1:0]  flush_asid_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [asid_width_p-1:0]  asid_i,
  input  logic [vtag_width_p-1:0]  vtag_i,
  input  logic [entry_width_p-1:0] entry_i,
  output logic                     ready_o,
  output logic                     v_o,
  output logic [entry_width_p-1:0] entry_o,
  output logic                     miss_v_o,
  output logic [vtag_width_p-1:0]  miss_vtag_o,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o,
  output logic [31:0]              bypass_cnt_o
);

  typedef `BP_TLB_TAG_S(asid_width_p, vtag_width_p) tag_s;
  typedef `BP_PTE_ENTRY_LEAF_S(ptag_width_p) pte_s;

  bp_tlb_fsm_e state_r;
  tag_s [els_p-1:0] tag_r;
  logic [els_p-1:0] valid_r, match;
  logic [asid_width_p-1:0] flush_asid_r;
  logic [lg_els_lp-1:0] idx_r, hit_way, free_way;
  logic [lg_els_lp-1:0] victim, fill_way;
  logic free_v, cam_hit, byp_hit, walk_clr;
  logic acc, lkup, pass, fill, cam_rd, lk_hit;
  logic full_flush, asid_flush, byp_clr;
  logic ram_v, ram_w;
  logic [entry_width_p-1:0] ram_q;
  logic ten_r, byp_v_r, byp_load_r;
  logic [asid_width_p-1:0] byp_asid_r;
  logic [vtag_width_p-1:0] byp_vtag_r;
  logic [entry_width_p-1:0] byp_entry_r, out_entry_r;
  logic src_ram_r;
  pte_s pt_pte;

  assign ready_o = (state_r == e_tlb_idle);
  assign full_flush = ready_o & flush_v_i & ~flush_asid_v_i;
  assign asid_flush = ready_o & flush_v_i & flush_asid_v_i;
  assign acc  = ready_o & v_i & ~flush_v_i;
  assign lkup = acc & ~w_i & translation_en_i;
  assign pass = acc & ~w_i & ~translation_en_i;
  assign fill = acc & w_i & translation_en_i;

  // descending scan leaves the lowest matching/free index
  always_comb begin
    match = '0;
    hit_way = '0;
    free_way = '0;
    free_v = 1'b0;
    for (int i = els_p - 1; i >= 0; i--) begin
      match[i] = valid_r[i] & (tag_r[i].vtag == vtag_i)
               & ((tag_r[i].asid == asid_i) | tag_r[i].g);
      if (match[i]) hit_way = lg_els_lp'(i);
      if (!valid_r[i]) begin
        free_way = lg_els_lp'(i);
        free_v = 1'b1;
      end
    end
  end

  assign cam_hit = |match;
  assign byp_hit = byp_v_r & (byp_asid_r == asid_i)
                 & (byp_vtag_r == vtag_i);
  assign cam_rd = lkup & ~byp_hit & cam_hit;
  assign lk_hit = lkup & (byp_hit | cam_hit);
  assign fill_way = cam_hit ? hit_way
                  : free_v ? free_way : victim;
  assign ram_v = fill | cam_rd;
  assign ram_w = fill;
  assign walk_clr = (state_r == e_tlb_walk) & valid_r[idx_r]
                  & (tag_r[idx_r].asid == flush_asid_r)
                  & ~tag_r[idx_r].g;
  assign byp_clr = fill | full_flush | asid_flush
                 | (ten_r & ~translation_en_i);

  always_comb begin
    pt_pte = '0;
    pt_pte.ptag = ptag_width_p'(vtag_i);
  end

  bsg_mem_1rw_sync #(
    .width_p(entry_width_p),
    .els_p(els_p)
  ) u_ram (
    .clk_i(clk_i),
    .v_i(ram_v),
    .w_i(ram_w),
    .addr_i(fill ? fill_way : hit_way),
    .data_i(entry_i),
    .data_o(ram_q)
  );

  bp_tlb_plru_tree #(.els_p(els_p)) u_plru (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .clear_i(full_flush),
    .touch_v_i(ram_v),
    .touch_way_i(fill ? fill_way : hit_way),
    .victim_o(victim)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r <= '0;
      tag_r <= '0;
    end else if (full_flush) begin
      valid_r <= '0;
    end else if (walk_clr) begin
      valid_r[idx_r] <= 1'b0;
    end else if (fill) begin
      valid_r[fill_way] <= 1'b1;
      tag_r[fill_way] <= '{asid: asid_i, vtag: vtag_i,
                           g: entry_i[bp_pte_g_bit_gp]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_tlb_idle;
      idx_r <= '0;
      flush_asid_r <= '0;
    end else begin
      unique case (state_r)
        e_tlb_idle: if (asid_flush) begin
          state_r <= e_tlb_walk;
          idx_r <= '0;
          flush_asid_r <= flush_asid_i;
        end
        e_tlb_walk: begin
          idx_r <= idx_r + 1'b1;
          if (idx_r == lg_els_lp'(els_p - 1))
            state_r <= e_tlb_idle;
        end
      endcase
    end
  end

  // bypass entry arrives from the RAM one cycle after the CAM hit
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ten_r <= 1'b0;
      byp_v_r <= 1'b0;
      byp_load_r <= 1'b0;
      byp_asid_r <= '0;
      byp_vtag_r <= '0;
      byp_entry_r <= '0;
      v_o <= 1'b0;
      miss_v_o <= 1'b0;
      miss_vtag_o <= '0;
      src_ram_r <= 1'b0;
      out_entry_r <= '0;
    end else begin
      ten_r <= translation_en_i;
      byp_load_r <= cam_rd;
      if (byp_load_r) byp_entry_r <= ram_q;
      if (byp_clr) begin
        byp_v_r <= 1'b0;
      end else if (cam_rd) begin
        byp_v_r <= 1'b1;
        byp_asid_r <= asid_i;
        byp_vtag_r <= vtag_i;
      end
      v_o <= pass | lk_hit;
      miss_v_o <= lkup & ~lk_hit;
      if (lkup & ~lk_hit) miss_vtag_o <= vtag_i;
      src_ram_r <= cam_rd;
      if (pass)
        out_entry_r <= entry_width_p'(pt_pte);
      else if (lkup & byp_hit)
        out_entry_r <= byp_load_r ? ram_q : byp_entry_r;
    end
  end

  assign entry_o = src_ram_r ? ram_q : out_entry_r;

`ifdef BP_TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_r, miss_cnt_r, byp_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_cnt_r <= '0;
      miss_cnt_r <= '0;
      byp_cnt_r <= '0;
    end else begin
      if (lk_hit & ~&hit_cnt_r)
        hit_cnt_r <= hit_cnt_r + 32'd1;
      if (lkup & ~lk_hit & ~&miss_cnt_r)
        miss_cnt_r <= miss_cnt_r + 32'd1;
      if (lkup & byp_hit & ~&byp_cnt_r)
        byp_cnt_r <= byp_cnt_r + 32'd1;
    end
  end

  assign hit_cnt_o = hit_cnt_r;
  assign miss_cnt_o = miss_cnt_r;
  assign bypass_cnt_o = byp_cnt_r;
`else
  assign hit_cnt_o = '0;
  assign miss_cnt_o = '0;
  assign bypass_cnt_o = '0;
`endif

endmodule
